// File: rtl/final_logic_arb.sv
// Output arbiter/router: drains NUM_VC show-ahead VC FIFOs one word per cycle
// and routes each word to a destination FIFO selected by a field in the word.
module final_logic_arb #(
    parameter int unsigned DATA_W   = 6,
    parameter int unsigned NUM_VC   = 2,
    parameter int unsigned NUM_DEST = 2,
    parameter int unsigned DEST_LSB = 4,
    parameter int unsigned ARB_MODE = 0,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_VC*DATA_W-1:0]   vc_data,
    input  logic [NUM_VC-1:0]          vc_empty,
    output logic [NUM_VC-1:0]          vc_pop,
    input  logic [NUM_DEST-1:0]        dest_almost_full,
    input  logic [NUM_DEST-1:0]        dest_full,
    output logic [NUM_DEST-1:0]        dest_push,
    output logic [DATA_W-1:0]          dest_data,
    output logic [NUM_DEST-1:0]        dest_error,
    output logic                       invalid_error,
    output logic [NUM_DEST*CNT_W-1:0]  dest_count
);

    localparam int unsigned DEST_W    = $clog2(NUM_DEST);
    localparam int unsigned VC_W      = $clog2(NUM_VC);
    localparam int unsigned DEST_SPAN = 1 << DEST_W;

    logic [NUM_VC-1:0][DEST_W-1:0] hd;
    logic [NUM_VC-1:0]             hd_inval;
    logic [NUM_VC-1:0]             elig;
    logic [DEST_SPAN-1:0]          af_pad;
    logic [VC_W-1:0]               rr_ptr;
    logic [VC_W-1:0]               rr_idx;
    logic [VC_W-1:0]               grant_idx;
    logic                          grant_vld;
    logic [DATA_W-1:0]             g_data;
    logic [DEST_W-1:0]             g_hd;
    logic                          g_inval;

    // Padding lets an out-of-range destination index the almost-full vector safely.
    assign af_pad = DEST_SPAN'(dest_almost_full);

    // Head destination decode and eligibility; invalid heads stay eligible so they drain.
    always_comb begin
        hd       = '0;
        hd_inval = '0;
        elig     = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            hd[i]       = vc_data[i*DATA_W + DEST_LSB +: DEST_W];
            hd_inval[i] = 32'(hd[i]) >= NUM_DEST;
            elig[i]     = !vc_empty[i] && (hd_inval[i] || !af_pad[hd[i]]);
        end
    end

    // Grant selection; loops run downward so the last hit is the highest-priority one.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        rr_idx    = '0;
        if (ARB_MODE == 0) begin
            for (int i = NUM_VC - 1; i >= 0; i--) begin
                if (elig[i]) begin
                    grant_vld = 1'b1;
                    grant_idx = VC_W'(i);
                end
            end
        end else begin
            for (int k = NUM_VC - 1; k >= 0; k--) begin
                rr_idx = VC_W'((32'(rr_ptr) + 32'(k)) % NUM_VC);
                if (elig[rr_idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = rr_idx;
                end
            end
        end
    end

    // Granted word and its destination.
    always_comb begin
        g_data  = '0;
        g_hd    = '0;
        g_inval = 1'b0;
        for (int i = 0; i < NUM_VC; i++) begin
            if (grant_idx == VC_W'(i)) begin
                g_data  = vc_data[i*DATA_W +: DATA_W];
                g_hd    = hd[i];
                g_inval = hd_inval[i];
            end
        end
    end

    always_comb begin
        vc_pop = '0;
        if (grant_vld && !reset) begin
            vc_pop[grant_idx] = 1'b1;
        end
    end

    // Output stage, error flags, delivery counters and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            dest_push     <= '0;
            dest_data     <= '0;
            dest_error    <= '0;
            invalid_error <= 1'b0;
            dest_count    <= '0;
            rr_ptr        <= '0;
        end else begin
            for (int d = 0; d < NUM_DEST; d++) begin
                dest_push[d] <= grant_vld && !g_inval && (g_hd == DEST_W'(d));
                if (dest_push[d] && dest_full[d]) begin
                    dest_error[d] <= 1'b1;
                end
                if (dest_push[d] && !dest_full[d]) begin
                    dest_count[d*CNT_W +: CNT_W] <= dest_count[d*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
            if (grant_vld) begin
                dest_data <= g_data;
                if (g_inval) begin
                    invalid_error <= 1'b1;
                end
                if (ARB_MODE != 0) begin
                    rr_ptr <= (grant_idx == VC_W'(NUM_VC - 1)) ? '0 : grant_idx + VC_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_final_logic_arb.sv
// Directed bench: a strict-priority 2x2 instance and a round-robin 3x3 instance
// with 2-bit counters, sharing clock and reset.
module tb_final_logic_arb;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Strict-priority instance (defaults)
    logic [11:0] vc_data;
    logic [1:0]  vc_empty, vc_pop, af, full, push, derr;
    logic [5:0]  dout;
    logic        inv;
    logic [15:0] cnt;

    // Round-robin instance
    logic [17:0] r_vc_data;
    logic [2:0]  r_empty, r_pop, r_af, r_full, r_push, r_derr;
    logic [5:0]  r_dout;
    logic        r_inv;
    logic [5:0]  r_cnt;

    int n_pass = 0;
    int n_chk  = 0;
    logic [1:0] wrap_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    final_logic_arb u_dut (
        .clk(clk), .reset(reset), .vc_data(vc_data), .vc_empty(vc_empty), .vc_pop(vc_pop),
        .dest_almost_full(af), .dest_full(full), .dest_push(push), .dest_data(dout),
        .dest_error(derr), .invalid_error(inv), .dest_count(cnt)
    );

    final_logic_arb #(.NUM_VC(3), .NUM_DEST(3), .ARB_MODE(1), .CNT_W(2)) u_rr (
        .clk(clk), .reset(reset), .vc_data(r_vc_data), .vc_empty(r_empty), .vc_pop(r_pop),
        .dest_almost_full(r_af), .dest_full(r_full), .dest_push(r_push), .dest_data(r_dout),
        .dest_error(r_derr), .invalid_error(r_inv), .dest_count(r_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        vc_data   = {6'b110110, 6'b100101};
        vc_empty  = 2'b00;
        af        = '0;
        full      = '0;
        r_vc_data = {6'b100010, 6'b010001, 6'b000000};
        r_empty   = 3'b000;
        r_af      = '0;
        r_full    = '0;

        // Reset held two cycles with all VCs non-empty
        tick();
        tick();
        check("rst_pop",   vc_pop, 2'b00);
        check("rst_rpop",  r_pop, 3'b000);
        check("rst_push",  push, 2'b00);
        check("rst_data",  dout, 6'd0);
        check("rst_err",   {derr, inv}, 3'b000);
        check("rst_cnt",   cnt, 16'd0);
        check("rst_rcnt",  {r_cnt, r_push, r_inv}, 10'd0);

        // Strict routing
        reset   = 1'b0;
        r_empty = 3'b111;
        #1;
        check("st_pop0", vc_pop, 2'b01);
        tick();
        check("st_push0", push, 2'b01);
        check("st_data0", dout, 6'b100101);
        vc_empty = 2'b01;
        #1;
        check("st_pop1", vc_pop, 2'b10);
        tick();
        check("st_push1", push, 2'b10);
        check("st_data1", dout, 6'b110110);
        check("st_cnt0", cnt[7:0], 8'd1);
        vc_empty = 2'b11;
        tick();
        check("idle_push", push, 2'b00);
        check("idle_data", dout, 6'b110110);
        check("idle_cnt1", cnt[15:8], 8'd1);

        // Back-pressure: dest 1 almost full, VC0 heads there, VC1 heads to dest 0
        vc_data  = {6'b000001, 6'b110100};
        vc_empty = 2'b00;
        af       = 2'b10;
        #1;
        check("bp_pop", vc_pop, 2'b10);
        tick();
        check("bp_push", {push, dout}, {2'b01, 6'b000001});
        af = 2'b00;
        #1;
        check("bp_pop_rel", vc_pop, 2'b01);
        tick();
        check("bp_push_rel", {push, dout}, {2'b10, 6'b110100});
        check("bp_cnt0", cnt[7:0], 8'd2);

        // Overflow on dest 0
        vc_data  = {6'b000001, 6'b000011};
        vc_empty = 2'b10;
        tick();
        check("ov_push", push, 2'b01);
        check("ov_cnt1", cnt[15:8], 8'd2);
        vc_empty = 2'b11;
        full     = 2'b01;
        tick();
        check("ov_err", derr, 2'b01);
        check("ov_cnt0", cnt[7:0], 8'd2);
        full = 2'b00;
        tick();
        check("ov_sticky", derr, 2'b01);

        // Reset mid-operation with words pending
        vc_empty = 2'b00;
        reset    = 1'b1;
        #1;
        check("mid_rst_pop", vc_pop, 2'b00);
        tick();
        reset = 1'b0;
        check("mid_rst_out", {push, derr, inv}, 5'b00000);
        vc_empty = 2'b11;
        tick();
        check("mid_rst_nopush", push, 2'b00);

        // Round-robin: all three VCs busy, then VC1 empty
        r_empty = 3'b000;
        for (int k = 0; k < 6; k++) begin
            #1;
            check($sformatf("rr_all%0d", k), r_pop, 3'b001 << (k % 3));
            tick();
            check($sformatf("rr_push%0d", k), r_push, 3'b001 << (k % 3));
        end
        r_empty = 3'b010;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("rr_skip%0d", k), r_pop, (k % 2 == 0) ? 3'b001 : 3'b100);
            tick();
        end

        // Invalid destination field 2'b11 with three destinations
        r_vc_data = {6'b100010, 6'b010001, 6'b110000};
        r_empty   = 3'b110;
        #1;
        check("inv_pop", r_pop, 3'b001);
        tick();
        r_empty = 3'b111;
        check("inv_push", r_push, 3'b000);
        check("inv_flag", r_inv, 1'b1);
        check("inv_data", r_dout, 6'b110000);
        tick();
        check("inv_sticky", r_inv, 1'b1);

        // Counter wrap on 2-bit counter, five pushes to dest 0
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        r_vc_data = {6'b100010, 6'b010001, 6'b000111};
        r_empty   = 3'b110;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 5) r_empty = 3'b111;
            if (k >= 2) check($sformatf("wrap%0d", k - 1), r_cnt[1:0], wrap_exp[k-2]);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
